// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field layout, sequencer states and field-extraction helpers.
package alu_pkg;

   localparam int OPC_W = 4;
   localparam int REG_W = 2;
   localparam int IMM_W = 8;

   localparam logic [OPC_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [OPC_W-1:0] ALU_SUB = 4'b0001;
   localparam logic [OPC_W-1:0] ALU_AND = 4'b0010;
   localparam logic [OPC_W-1:0] ALU_OR  = 4'b0011;
   localparam logic [OPC_W-1:0] ALU_XOR = 4'b0100;
   localparam logic [OPC_W-1:0] ALU_NOT = 4'b0101;
   localparam logic [OPC_W-1:0] ALU_SHL = 4'b0110;
   localparam logic [OPC_W-1:0] ALU_SHR = 4'b0111;

   localparam int MODE_BIT = 15;
   localparam int OPC_LSB  = 11;
   localparam int RD_LSB   = 9;
   localparam int RS1_LSB  = 7;
   localparam int RS2_LSB  = 5;
   localparam int IMM_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   function automatic logic insn_is_li(input logic [15:0] insn);
      return insn[MODE_BIT];
   endfunction

   function automatic logic [OPC_W-1:0] insn_opc(input logic [15:0] insn);
      return insn[OPC_LSB +: OPC_W];
   endfunction

   function automatic logic [REG_W-1:0] insn_rd(input logic [15:0] insn);
      return insn[RD_LSB +: REG_W];
   endfunction

   function automatic logic [REG_W-1:0] insn_rs1(input logic [15:0] insn);
      return insn[RS1_LSB +: REG_W];
   endfunction

   function automatic logic [REG_W-1:0] insn_rs2(input logic [15:0] insn);
      return insn[RS2_LSB +: REG_W];
   endfunction

   function automatic logic [IMM_W-1:0] insn_imm(input logic [15:0] insn);
      return insn[IMM_LSB +: IMM_W];
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by the issue controller; carry is the bit shifted
// or carried out of the datapath, borrow for SUB.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OPC_W-1:0]  opcode,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              carry
);

   logic [DATA_W:0] wide;

   always_comb begin
      wide = '0;
      case (opcode)
         ALU_ADD: wide = {1'b0, a} + {1'b0, b};
         ALU_SUB: wide = {1'b0, a} - {1'b0, b};
         ALU_AND: wide = {1'b0, a & b};
         ALU_OR:  wide = {1'b0, a | b};
         ALU_XOR: wide = {1'b0, a ^ b};
         ALU_NOT: wide = {1'b0, ~a};
         ALU_SHL: wide = {a, 1'b0};
         ALU_SHR: wide = {a[0], 1'b0, a[DATA_W-1:1]};
         default: wide = {1'b0, a};
      endcase
   end

   assign result = wide[DATA_W-1:0];
   assign carry  = wide[DATA_W];
   assign zero   = (result == '0);

endmodule

// File: rtl/alu_regfile.sv
// Register file with two operand read ports, a debug read port and one
// synchronous write port; all registers clear on reset.
module alu_regfile #(
   parameter int DATA_W = 8,
   parameter int NREG   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [$clog2(NREG)-1:0] rs1_sel,
   input  logic [$clog2(NREG)-1:0] rs2_sel,
   output logic [DATA_W-1:0]       rs1_data,
   output logic [DATA_W-1:0]       rs2_data,
   input  logic [$clog2(NREG)-1:0] dbg_sel,
   output logic [DATA_W-1:0]       dbg_data,
   input  logic                    we,
   input  logic [$clog2(NREG)-1:0] wa,
   input  logic [DATA_W-1:0]       wd
);

   logic [DATA_W-1:0] regs [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign rs1_data = regs[rs1_sel];
   assign rs2_data = regs[rs2_sel];
   assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serializing sequencer around the combinational alu: accept, execute for one
// cycle, write back to the register file and present the result downstream.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREG   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_insn,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OPC_W-1:0]  alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_carry,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_zero,
   output logic              out_carry,
   input  logic [REG_W-1:0]  dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   state_t            state, state_nx;
   logic [REG_W-1:0]  rd_q;
   logic [DATA_W-1:0] rs1_data, rs2_data;
   logic              we, zero_nx, carry_nx, latch_alu;
   logic [REG_W-1:0]  wa;
   logic [DATA_W-1:0] wd;

   alu_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs1_sel  (insn_rs1(in_insn)),
      .rs2_sel  (insn_rs2(in_insn)),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data),
      .we       (we),
      .wa       (wa),
      .wd       (wd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // The write port doubles as the completion event: it loads the regfile,
   // the flag register and the output registers together.
   always_comb begin
      state_nx  = state;
      we        = 1'b0;
      wa        = rd_q;
      wd        = alu_result;
      zero_nx   = alu_zero;
      carry_nx  = alu_carry;
      latch_alu = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (insn_is_li(in_insn)) begin
                  we       = 1'b1;
                  wa       = insn_rd(in_insn);
                  wd       = insn_imm(in_insn);
                  zero_nx  = (insn_imm(in_insn) == '0);
                  carry_nx = 1'b0;
                  state_nx = WB;
               end else begin
                  latch_alu = 1'b1;
                  state_nx  = EXEC;
               end
            end
         end
         EXEC: begin
            we       = 1'b1;
            state_nx = WB;
         end
         WB: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
         rd_q   <= '0;
      end else if (latch_alu) begin
         alu_a  <= rs1_data;
         alu_b  <= rs2_data;
         alu_op <= insn_opc(in_insn);
         rd_q   <= insn_rd(in_insn);
      end
   end

   // out_zero/out_carry are the flag register itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_rd    <= '0;
         out_zero  <= 1'b0;
         out_carry <= 1'b0;
      end else if (we) begin
         out_data  <= wd;
         out_rd    <= wa;
         out_zero  <= zero_nx;
         out_carry <= carry_nx;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == WB);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl wired to the real alu; each test task
// drives its scenario and compares against hand-computed values.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_insn = '0;
   logic [7:0]  alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   logic        alu_zero, alu_carry;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic [1:0]  out_rd;
   logic        out_zero, out_carry;
   logic [1:0]  dbg_sel = '0;
   logic [7:0]  dbg_data;

   int vectors = 0;
   int miscompares = 0;

   alu_issue_ctrl #(.DATA_W(8), .NREG(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_insn    (in_insn),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .alu_carry  (alu_carry),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_rd     (out_rd),
      .out_zero   (out_zero),
      .out_carry  (out_carry),
      .dbg_sel    (dbg_sel),
      .dbg_data   (dbg_data)
   );

   alu #(.DATA_W(8)) u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .opcode (alu_op),
      .result (alu_result),
      .zero   (alu_zero),
      .carry  (alu_carry)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mk_li(input logic [1:0] rd, input logic [7:0] imm);
      return {1'b1, 4'b0000, rd, 1'b0, imm};
   endfunction

   function automatic logic [15:0] mk_alu(input logic [3:0] op, input logic [1:0] rd,
                                          input logic [1:0] rs1, input logic [1:0] rs2);
      return {1'b0, op, rd, rs1, rs2, 5'b00000};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for a single edge; returns #1 after that edge.
   task automatic applyStimulus(input logic [15:0] insn);
      in_insn  = insn;
      in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      next_cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      next_cycle();
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL reset_handshake: got ready/valid=%b expected 10", {in_ready, out_valid});
      end
      vectors++;
      if ({alu_a, alu_b, alu_op, out_data, out_rd, out_zero, out_carry} !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {alu_a, alu_b, alu_op, out_data, out_rd, out_zero, out_carry});
      end
      for (int i = 0; i < 4; i++) begin
         dbg_sel = 2'(i);
         #1;
         vectors++;
         if (dbg_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_dbg_r%0d: got %h expected 00", i, dbg_data);
         end
      end
   endtask

   task automatic test_add();
      applyStimulus(mk_li(2'd0, 8'h02));
      vectors++;
      if ({out_valid, out_rd, out_data} !== {1'b1, 2'd0, 8'h02}) begin
         miscompares++;
         $display("[TB] FAIL li_r0: got v/rd/data=%h expected %h", {out_valid, out_rd, out_data}, {1'b1, 2'd0, 8'h02});
      end
      handshake();
      applyStimulus(mk_li(2'd1, 8'h01));
      handshake();
      applyStimulus(mk_alu(ALU_ADD, 2'd2, 2'd0, 2'd1));
      vectors++;
      if ({out_valid, in_ready, alu_a, alu_b, alu_op} !== {2'b00, 8'h02, 8'h01, 4'h0}) begin
         miscompares++;
         $display("[TB] FAIL add_exec: got %h expected %h", {out_valid, in_ready, alu_a, alu_b, alu_op},
                  {2'b00, 8'h02, 8'h01, 4'h0});
      end
      next_cycle();
      vectors++;
      if ({out_valid, out_rd, out_data, out_zero, out_carry} !== {1'b1, 2'd2, 8'h03, 2'b00}) begin
         miscompares++;
         $display("[TB] FAIL add_result: got %h expected %h", {out_valid, out_rd, out_data, out_zero, out_carry},
                  {1'b1, 2'd2, 8'h03, 2'b00});
      end
      dbg_sel = 2'd2;
      #1;
      vectors++;
      if (dbg_data !== 8'h03) begin
         miscompares++;
         $display("[TB] FAIL add_dbg_r2: got %h expected 03", dbg_data);
      end
      handshake();
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL add_release: got ready/valid=%b expected 10", {in_ready, out_valid});
      end
   endtask

   task automatic test_overflow();
      applyStimulus(mk_li(2'd0, 8'hFF));
      handshake();
      applyStimulus(mk_li(2'd1, 8'h01));
      handshake();
      applyStimulus(mk_alu(ALU_ADD, 2'd3, 2'd0, 2'd1));
      next_cycle();
      vectors++;
      if ({out_valid, out_rd, out_data, out_zero, out_carry} !== {1'b1, 2'd3, 8'h00, 2'b11}) begin
         miscompares++;
         $display("[TB] FAIL ovf_result: got %h expected %h", {out_valid, out_rd, out_data, out_zero, out_carry},
                  {1'b1, 2'd3, 8'h00, 2'b11});
      end
      handshake();
      applyStimulus(mk_li(2'd0, 8'h00));
      vectors++;
      if ({out_valid, out_rd, out_data, out_zero, out_carry} !== {1'b1, 2'd0, 8'h00, 2'b10}) begin
         miscompares++;
         $display("[TB] FAIL li_zero_flags: got %h expected %h", {out_valid, out_rd, out_data, out_zero, out_carry},
                  {1'b1, 2'd0, 8'h00, 2'b10});
      end
      vectors++;
      if ({alu_a, alu_b, alu_op} !== {8'hFF, 8'h01, 4'h0}) begin
         miscompares++;
         $display("[TB] FAIL li_keeps_alu_in: got %h expected %h", {alu_a, alu_b, alu_op}, {8'hFF, 8'h01, 4'h0});
      end
      handshake();
   endtask

   task automatic test_backpressure();
      applyStimulus(mk_li(2'd2, 8'h5A));
      for (int i = 0; i < 5; i++) begin
         in_insn  = mk_li(2'd2, 8'h11);
         in_valid = (i % 2 == 0);
         vectors++;
         if ({out_valid, in_ready, out_rd, out_data, out_zero, out_carry} !== {2'b10, 2'd2, 8'h5A, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL bp_hold_%0d: got %h expected %h", i,
                     {out_valid, in_ready, out_rd, out_data, out_zero, out_carry}, {2'b10, 2'd2, 8'h5A, 2'b00});
         end
         next_cycle();
      end
      in_valid = 1'b0;
      dbg_sel  = 2'd2;
      #1;
      vectors++;
      if ({out_valid, dbg_data} !== {1'b1, 8'h5A}) begin
         miscompares++;
         $display("[TB] FAIL bp_ignored_insn: got %h expected %h", {out_valid, dbg_data}, {1'b1, 8'h5A});
      end
      handshake();
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL bp_release: got ready/valid=%b expected 10", {in_ready, out_valid});
      end
      next_cycle();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bp_single_result: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_alias();
      applyStimulus(mk_li(2'd1, 8'h05));
      handshake();
      applyStimulus(mk_alu(ALU_ADD, 2'd1, 2'd1, 2'd1));
      vectors++;
      if ({alu_a, alu_b} !== {8'h05, 8'h05}) begin
         miscompares++;
         $display("[TB] FAIL alias_operands: got %h expected 0505", {alu_a, alu_b});
      end
      next_cycle();
      dbg_sel = 2'd1;
      #1;
      vectors++;
      if ({out_valid, out_rd, out_data, dbg_data} !== {1'b1, 2'd1, 8'h0A, 8'h0A}) begin
         miscompares++;
         $display("[TB] FAIL alias_result: got %h expected %h", {out_valid, out_rd, out_data, dbg_data},
                  {1'b1, 2'd1, 8'h0A, 8'h0A});
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      applyStimulus(mk_li(2'd0, 8'h33));
      handshake();
      applyStimulus(mk_alu(ALU_ADD, 2'd3, 2'd0, 2'd0));
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({out_valid, in_ready, alu_a, alu_b, out_data, out_zero, out_carry} !== {2'b01, 24'h0, 2'b00}) begin
         miscompares++;
         $display("[TB] FAIL midrst_async: got %h expected %h",
                  {out_valid, in_ready, alu_a, alu_b, out_data, out_zero, out_carry}, {2'b01, 24'h0, 2'b00});
      end
      dbg_sel = 2'd0;
      #1;
      vectors++;
      if (dbg_data !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL midrst_r0_clear: got %h expected 00", dbg_data);
      end
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         vectors++;
         if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL midrst_no_wb_%0d: got valid/ready=%b expected 01", i, {out_valid, in_ready});
         end
      end
      dbg_sel = 2'd3;
      #1;
      vectors++;
      if (dbg_data !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL midrst_r3_unwritten: got %h expected 00", dbg_data);
      end
   endtask

   initial begin
      $display("[TB] starting alu_issue_ctrl directed tests");
      test_reset();
      test_add();
      test_overflow();
      test_backpressure();
      test_alias();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
